ddr_ts_pkt_align: RTL and testbench
===================================

# ddr_ts_pkt_align

Store-and-forward packet aligner on the DDR3 read-return path. It consumes the 9-bit byte stream produced by the DDR read treatment stage: bits [7:0] carry the data byte and bit 8 marks the first byte of a packet. It forwards only complete, sync-valid 188-byte transport-stream packets to the downstream TS mux, through a ready/valid handshake. Buffering is a two-bank ping-pong: malformed packets are discarded, and packets that arrive with no free bank are dropped and counted.

## Interface
Parameters:
- PKT_LEN, 188, packet length in bytes (bank depth).
- SYNC_BYTE, 8'h47, required value of byte 0.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- din  in  9  [8] = start-of-packet flag, [7:0] = byte.
- din_en  in  1  din valid this cycle; no backpressure to the source.
- dout_rdy  in  1  downstream can take a byte next cycle.
- dout  out  8  output byte.
- dout_en  out  1  dout valid.
- dout_sop  out  1  with dout_en, marks byte 0.
- dout_eop  out  1  with dout_en, marks byte PKT_LEN-1.
- err_sync_cnt  out  16  count of SOP bytes that were not SYNC_BYTE.
- err_len_cnt  out  16  count of packets cut short by an early SOP.
- drop_cnt  out  16  count of valid-sync packets dropped because no bank was free.

## Operation
- Storage: 2 banks × PKT_LEN × 8 bits, synchronous-read RAM. Each bank has a full flag. Write pointer and read pointer each toggle 0→1→0, so output order equals arrival order.

Write FSM. States: W_IDLE, W_FILL, W_DISCARD.
- Handling of a SOP byte (din_en & din[8]), applied in any state:
  - If byte ≠ SYNC_BYTE: increment err_sync_cnt; go to W_IDLE.
  - Else, if the bank at the write pointer is full: increment drop_cnt; go to W_DISCARD.
  - Otherwise: write the byte at index 0; set wcnt=1; go to W_FILL.
- W_IDLE / W_DISCARD: non-SOP bytes are ignored. This includes bytes beyond PKT_LEN of a long packet.
- W_FILL, non-SOP byte: write at index wcnt; wcnt++.
  - When index PKT_LEN-1 is written: set the bank's full flag; toggle the write pointer; go to W_IDLE.
- W_FILL, SOP byte before wcnt reaches PKT_LEN: increment err_len_cnt and abandon the partial bank (it stays not-full, and the write pointer is unchanged). The same SOP byte is then processed by the SOP rule above in that same cycle.

Read FSM. States: R_IDLE, R_SEND.
- R_IDLE → R_SEND when the bank at the read pointer is full; rcnt=0.
- R_SEND: each cycle with dout_rdy=1 issues a RAM read at rcnt; rcnt++. The byte appears on dout with dout_en=1 in the next cycle.
  - dout_sop = (byte index 0); dout_eop = (byte index PKT_LEN-1).
  - When index PKT_LEN-1 is issued: clear that bank's full flag; toggle the read pointer; go to R_IDLE.
- dout_rdy=0 pauses the read side with no loss and no repeat. dout_en=0 in the following cycle.

Arithmetic and flag rules:
- wcnt and rcnt are 8 bits.
- All counters saturate at 16'hFFFF.
- A full flag cleared on edge t is visible to a SOP sampled in the cycle after edge t. It is not visible to a SOP sampled before that edge.

## Timing
- Reset values: dout=0, dout_en=0, dout_sop=0, dout_eop=0, all counters 0, both full flags 0, both pointers 0, FSMs in W_IDLE / R_IDLE.
- Reset mid-operation: on the reset edge, all state is cleared. Any packet in flight on the output is truncated with no eop. dout_en is 0 from the cycle after the reset edge.
- Latency: last input byte sampled at edge t → full flag set at t → R_SEND at t+1 → dout_sop at t+2 (with dout_rdy=1 from t+1).
- Throughput: with dout_rdy held high, one packet is PKT_LEN consecutive dout_en cycles.
  - One idle cycle separates back-to-back packets, spent in R_IDLE.
- Simultaneous events:
  - The write side filling bank A while the read side drains bank B in the same cycle is legal.
  - A write that completes bank X on the same edge that the read side frees bank Y is legal; both flag updates apply.

## Test plan
- Single packet: one packet of 188 bytes (0x47, 1, 2, …) with continuous din_en, dout_rdy=1 → dout_sop at 2 cycles after the last input byte, then 188 dout_en cycles reproducing the bytes, eop on 0xBB-index byte 187; counters stay 0.
- Bad sync: SOP byte 0x48 followed by 187 bytes, then a good packet → err_sync_cnt=1; only the good packet is output.
- Short packet: SOP plus 100 bytes, then a new good SOP packet → err_len_cnt=1; the good packet is output intact in bank order.
- Overflow: dout_rdy=0 while 3 good packets arrive → drop_cnt=1. Then set dout_rdy=1 → packets 1 and 2 are output, with 1 idle cycle between them.
- Backpressure: toggle dout_rdy randomly at 50% during a packet → all 188 bytes are output in order, with no duplicates; the dout_en count equals the dout_rdy-high count in R_SEND.
- Reset mid-operation: assert rst while the output is at byte 90 → dout_en=0 on the next cycle and all counters=0. A subsequent good packet is output normally.

Source files
------------

// File: rtl/ddr_ts_pkt_align.sv
// ---------------------------------------------------------------------------
// ddr_ts_pkt_align
//
// Store-and-forward transport-stream packet aligner for the DDR3 read-return
// path. Incoming bytes are collected into one of two ping-pong banks; only
// complete packets that start with the sync byte are forwarded downstream
// through a ready/valid handshake. Packets with a bad sync byte or that are
// cut short by an early start-of-packet are discarded. A good packet that
// arrives while the next bank is still occupied is dropped.
//
// Ports:
//   clk           single clock for all logic
//   rst           synchronous, active-high reset
//   din[8:0]      [8] = start-of-packet flag, [7:0] = data byte
//   din_en        din valid this cycle (no backpressure to the source)
//   dout_rdy      downstream can take a byte next cycle
//   dout[7:0]     output byte
//   dout_en       dout valid
//   dout_sop      with dout_en, byte 0 of a packet
//   dout_eop      with dout_en, byte PKT_LEN-1 of a packet
//   err_sync_cnt  SOP bytes that were not SYNC_BYTE (saturating)
//   err_len_cnt   packets cut short by an early SOP (saturating)
//   drop_cnt      good packets dropped for lack of a free bank (saturating)
// ---------------------------------------------------------------------------
module ddr_ts_pkt_align #(
    parameter int         PKT_LEN   = 188,
    parameter logic [7:0] SYNC_BYTE = 8'h47
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  din,
    input  logic        din_en,
    input  logic        dout_rdy,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [15:0] err_sync_cnt,
    output logic [15:0] err_len_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} w_state_t;
    typedef enum logic       {R_IDLE, R_SEND}            r_state_t;

    w_state_t    w_state_reg;
    logic [7:0]  wcnt_reg;
    logic        wptr_reg;

    r_state_t    r_state_reg;
    logic [7:0]  rcnt_reg;
    logic        rptr_reg;
    logic        rd_bank_reg;

    logic [1:0]  full_reg;

    logic [15:0] err_sync_cnt_reg;
    logic [15:0] err_len_cnt_reg;
    logic [15:0] drop_cnt_reg;

    logic        dout_en_reg;
    logic        dout_sop_reg;
    logic        dout_eop_reg;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Write/read strobes shared by the FSMs, the full flags and the RAMs
    // -----------------------------------------------------------------------
    logic       sop_in;
    logic       sync_ok;
    logic       body_in;
    logic       wr_en;
    logic [7:0] wr_idx;
    logic       wr_done;
    logic       rd_issue;
    logic       rd_done;

    always_comb begin
        sop_in   = din_en & din[8];
        sync_ok  = (din[7:0] == SYNC_BYTE);
        body_in  = din_en & ~din[8] & (w_state_reg == W_FILL);
        // A good SOP starts a bank regardless of the current write state.
        wr_en    = (sop_in & sync_ok & ~full_reg[wptr_reg]) | body_in;
        wr_idx   = sop_in ? 8'd0 : wcnt_reg;
        wr_done  = body_in & (wcnt_reg == LAST_IDX);
        rd_issue = (r_state_reg == R_SEND) & dout_rdy;
        rd_done  = rd_issue & (rcnt_reg == LAST_IDX);
    end

    // -----------------------------------------------------------------------
    // Ping-pong banks: one synchronous-read RAM per bank
    // -----------------------------------------------------------------------
    logic [7:0] bank_q [2];

    for (genvar gi = 0; gi < 2; gi++) begin : bank_g
        logic [7:0] mem [0:PKT_LEN-1];
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (wr_en && (wptr_reg == 1'(gi))) begin
                mem[wr_idx] <= din[7:0];
            end
        end

        // Read register resets so dout is 0 out of reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_reg <= 8'd0;
            end else if (rd_issue && (rptr_reg == 1'(gi))) begin
                q_reg <= mem[rcnt_reg];
            end
        end

        assign bank_q[gi] = q_reg;
    end

    // -----------------------------------------------------------------------
    // Full flags. Write completes bank wptr (known not full), read frees bank
    // rptr (known full), so set and clear never target the same bank.
    // -----------------------------------------------------------------------
    logic [1:0] full_set;
    logic [1:0] full_clr;

    always_comb begin
        full_set = wr_done ? (2'b01 << wptr_reg) : 2'b00;
        full_clr = rd_done ? (2'b01 << rptr_reg) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 2'b00;
        end else begin
            full_reg <= (full_reg & ~full_clr) | full_set;
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg      <= W_IDLE;
            wcnt_reg         <= 8'd0;
            wptr_reg         <= 1'b0;
            err_sync_cnt_reg <= 16'd0;
            err_len_cnt_reg  <= 16'd0;
            drop_cnt_reg     <= 16'd0;
        end else if (din_en) begin
            if (din[8]) begin
                // Any SOP while filling means the previous packet was short;
                // the partial bank is simply abandoned (flag and pointer kept).
                if (w_state_reg == W_FILL) begin
                    err_len_cnt_reg <= sat_inc(err_len_cnt_reg);
                end
                if (!sync_ok) begin
                    err_sync_cnt_reg <= sat_inc(err_sync_cnt_reg);
                    w_state_reg      <= W_IDLE;
                end else if (full_reg[wptr_reg]) begin
                    drop_cnt_reg <= sat_inc(drop_cnt_reg);
                    w_state_reg  <= W_DISCARD;
                end else begin
                    wcnt_reg    <= 8'd1;
                    w_state_reg <= W_FILL;
                end
            end else if (w_state_reg == W_FILL) begin
                wcnt_reg <= wcnt_reg + 8'd1;
                if (wcnt_reg == LAST_IDX) begin
                    wptr_reg    <= ~wptr_reg;
                    w_state_reg <= W_IDLE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM with registered output flags; the byte itself comes from the
    // bank read register selected by the bank of the issued read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg  <= R_IDLE;
            rcnt_reg     <= 8'd0;
            rptr_reg     <= 1'b0;
            rd_bank_reg  <= 1'b0;
            dout_en_reg  <= 1'b0;
            dout_sop_reg <= 1'b0;
            dout_eop_reg <= 1'b0;
        end else begin
            dout_en_reg  <= rd_issue;
            dout_sop_reg <= rd_issue & (rcnt_reg == 8'd0);
            dout_eop_reg <= rd_done;
            if (rd_issue) begin
                rd_bank_reg <= rptr_reg;
            end
            case (r_state_reg)
                R_IDLE: begin
                    if (full_reg[rptr_reg]) begin
                        rcnt_reg    <= 8'd0;
                        r_state_reg <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (dout_rdy) begin
                        rcnt_reg <= rcnt_reg + 8'd1;
                        if (rcnt_reg == LAST_IDX) begin
                            rptr_reg    <= ~rptr_reg;
                            r_state_reg <= R_IDLE;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign dout         = bank_q[rd_bank_reg];
    assign dout_en      = dout_en_reg;
    assign dout_sop     = dout_sop_reg;
    assign dout_eop     = dout_eop_reg;
    assign err_sync_cnt = err_sync_cnt_reg;
    assign err_len_cnt  = err_len_cnt_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_ddr_ts_pkt_align.sv
// ---------------------------------------------------------------------------
// tb_ddr_ts_pkt_align
//
// Scoreboard bench: send_pkt pushes the expected {sop, eop, byte} of every
// packet that should come out; the monitor pops on each dout_en cycle.
// ---------------------------------------------------------------------------
module tb_ddr_ts_pkt_align;

    localparam int PKT_LEN = 188;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  din = 9'd0;
    logic        din_en = 1'b0;
    logic        dout_rdy = 1'b1;
    logic [7:0]  dout;
    logic        dout_en;
    logic        dout_sop;
    logic        dout_eop;
    logic [15:0] err_sync_cnt;
    logic [15:0] err_len_cnt;
    logic [15:0] drop_cnt;

    ddr_ts_pkt_align #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(8'h47)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_en       (din_en),
        .dout_rdy     (dout_rdy),
        .dout         (dout),
        .dout_en      (dout_en),
        .dout_sop     (dout_sop),
        .dout_eop     (dout_eop),
        .err_sync_cnt (err_sync_cnt),
        .err_len_cnt  (err_len_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rx_cnt = 0;
    int rx_base = 0;
    logic [9:0] exp_q [$];
    logic [9:0] exp_e;
    int sop_cyc [$];
    int eop_cyc [$];

    always @(posedge clk) cyc++;

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (!rst && dout_en) begin
            rx_cnt++;
            total++;
            if (dout_sop) sop_cyc.push_back(cyc);
            if (dout_eop) eop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got byte=%02h sop=%0b eop=%0b, required no output",
                         dout, dout_sop, dout_eop);
            end else begin
                exp_e = exp_q.pop_front();
                if ({dout_sop, dout_eop, dout} !== exp_e) begin
                    bad++;
                    $display("FAIL out_byte: got sop=%0b eop=%0b byte=%02h, required sop=%0b eop=%0b byte=%02h",
                             dout_sop, dout_eop, dout, exp_e[9], exp_e[8], exp_e[7:0]);
                end
            end
            if (dout_eop) $display("rx packet complete at cycle %0d", cyc);
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Byte 0 = b0 with SOP; byte i = (i + off) mod 256 afterwards.
    task automatic send_pkt(input logic [7:0] b0, input int n, input int off, input bit expect_out);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            b      = (i == 0) ? b0 : 8'(i + off);
            din    = {(i == 0), b};
            din_en = 1'b1;
            if (expect_out) exp_q.push_back({(i == 0), (i == n - 1), b});
        end
        $display("tx packet: sop=%02h len=%0d off=%0d expect_out=%0b", b0, n, off, expect_out);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        din_en = 1'b0;
        din    = 9'd0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dout_en", dout_en, 0);
        check("rst_dout", dout, 0);
        check("rst_sop", dout_sop, 0);
        check("rst_eop", dout_eop, 0);
        check("rst_err_sync", err_sync_cnt, 0);
        check("rst_err_len", err_len_cnt, 0);
        check("rst_drop", drop_cnt, 0);

        // Single packet with latency check
        send_pkt(8'h47, PKT_LEN, 0, 1'b1);
        idle();                       // edge t: last byte sampled
        @(negedge clk);               // after t
        @(negedge clk);               // after t+1: still in transition to R_SEND
        check("lat_no_early_out", dout_en, 0);
        @(negedge clk);               // after t+2: first byte
        check("lat_sop", {dout_en, dout_sop}, 3);
        wait_drain("drain_single", 400);
        check("single_err_sync", err_sync_cnt, 0);
        check("single_err_len", err_len_cnt, 0);
        check("single_drop", drop_cnt, 0);

        // Bad sync then good packet
        send_pkt(8'h48, PKT_LEN, 0, 1'b0);
        send_pkt(8'h47, PKT_LEN, 5, 1'b1);
        idle();
        wait_drain("drain_badsync", 400);
        check("badsync_err_sync", err_sync_cnt, 1);

        // Short packet (SOP + 100 bytes) then good packet back to back
        send_pkt(8'h47, 101, 9, 1'b0);
        send_pkt(8'h47, PKT_LEN, 17, 1'b1);
        idle();
        wait_drain("drain_short", 400);
        check("short_err_len", err_len_cnt, 1);
        check("short_err_sync", err_sync_cnt, 1);

        // Overflow: three packets with the output held off
        @(posedge clk);
        #1 dout_rdy = 1'b0;
        send_pkt(8'h47, PKT_LEN, 30, 1'b1);
        send_pkt(8'h47, PKT_LEN, 40, 1'b1);
        send_pkt(8'h47, PKT_LEN, 50, 1'b0);
        idle();
        repeat (10) @(negedge clk);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_held", exp_q.size(), 2 * PKT_LEN);
        sop_cyc.delete();
        eop_cyc.delete();
        @(posedge clk);
        #1 dout_rdy = 1'b1;
        wait_drain("drain_ovf", 1000);
        if (sop_cyc.size() >= 2 && eop_cyc.size() >= 1)
            check("ovf_gap", sop_cyc[1] - eop_cyc[0], 2);
        else
            check("ovf_sop_count", sop_cyc.size(), 2);

        // Backpressure: random dout_rdy during one packet
        rx_base = rx_cnt;
        fork
            begin
                send_pkt(8'h47, PKT_LEN, 60, 1'b1);
                idle();
            end
            begin
                repeat (400) begin
                    @(posedge clk);
                    #1 dout_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk);
        #1 dout_rdy = 1'b1;
        wait_drain("drain_bp", 1000);
        check("bp_byte_count", rx_cnt - rx_base, PKT_LEN);

        // Reset in the middle of an output packet
        rx_base = rx_cnt;
        send_pkt(8'h47, PKT_LEN, 70, 1'b1);
        idle();
        for (int k = 0; k < 1000 && (rx_cnt - rx_base) < 90; k++) @(negedge clk);
        check("mid_reached_90", rx_cnt - rx_base, 90);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dout_en", dout_en, 0);
        check("mid_rst_err_sync", err_sync_cnt, 0);
        check("mid_rst_err_len", err_len_cnt, 0);
        check("mid_rst_drop", drop_cnt, 0);
        rx_base = rx_cnt;
        send_pkt(8'h47, PKT_LEN, 80, 1'b1);
        idle();
        wait_drain("drain_after_rst", 400);
        check("after_rst_count", rx_cnt - rx_base, PKT_LEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
